wb_periph_arbiter: RTL and testbench

WB_PERIPH_ARBITER -- requirements
Module: wb_periph_arbiter

---
 rtl/wb_periph_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_periph_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_periph_arbiter.sv
// Wishbone classic slave that decodes a 4 KB window per peripheral and
// forwards one transaction at a time onto a shared peripheral bus with
// one-hot strobes. Unanswered requests time out and return a bus-error
// word. Address decode errors are answered immediately without a strobe.
module wb_periph_arbiter #(
  parameter int          NPERIPH  = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic [NPERIPH-1:0]    p_cyc_o,
  output logic [NPERIPH-1:0]    p_stb_o,
  output logic                  p_we_o,
  output logic [3:0]            p_sel_o,
  output logic [11:0]           p_adr_o,
  output logic [31:0]           p_dat_o,
  input  logic [NPERIPH-1:0]    p_ack_i,
  input  logic [32*NPERIPH-1:0] p_dat_i,
  output logic                  err_irq_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]         state;
  logic [7:0]         wait_cnt;
  logic [1:0]         idx_q;

  logic [1:0]         dec_idx;
  logic               dec_err;
  logic [NPERIPH-1:0] dec_onehot;
  logic               sel_ack;
  logic [31:0]        sel_dat;

  // Address bits above the decode field are deliberately ignored.
  logic               unused_adr;
  assign unused_adr = ^wbs_adr_i[31:16];

  // Decode the incoming request address into a peripheral index and one-hot strobe.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    dec_idx    = wbs_adr_i[13:12];
    dec_err    = (wbs_adr_i[15:14] != 2'b00) || (int'(dec_idx) >= NPERIPH);
    dec_onehot = '0;
    for (int k = 0; k < NPERIPH; k++) begin
      if (int'(dec_idx) == k) dec_onehot[k] = 1'b1;
    end
  end

  // Select the ack and read data of the addressed peripheral only; others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int k = 0; k < NPERIPH; k++) begin
      if (int'(idx_q) == k) begin
        sel_ack = p_ack_i[k];
        sel_dat = p_dat_i[32*k +: 32];
      end
    end
  end

  // Transaction FSM; every output is a flop so nothing combinational leaks out.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      idx_q     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      p_cyc_o   <= '0;
      p_stb_o   <= '0;
      p_we_o    <= 1'b0;
      p_sel_o   <= '0;
      p_adr_o   <= '0;
      p_dat_o   <= '0;
      err_irq_o <= 1'b0;
    end else begin
      err_irq_o <= 1'b0;
      case (state)
        IDLE: begin
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          if (wbs_cyc_i && wbs_stb_i) begin
            if (dec_err) begin
              // Unmapped address: answer straight away, never touch a peripheral.
              wbs_ack_o <= 1'b1;
              wbs_dat_o <= ERR_DATA;
              err_irq_o <= 1'b1;
              state     <= RESP;
            end else begin
              idx_q    <= dec_idx;
              p_we_o   <= wbs_we_i;
              p_sel_o  <= wbs_sel_i;
              p_adr_o  <= wbs_adr_i[11:0];
              p_dat_o  <= wbs_dat_i;
              p_cyc_o  <= dec_onehot;
              p_stb_o  <= dec_onehot;
              wait_cnt <= '0;
              state    <= ACTIVE;
            end
          end
        end

        ACTIVE: begin
          if (!wbs_cyc_i) begin
            // Master abandoned the cycle: release the peripheral silently.
            p_cyc_o <= '0;
            p_stb_o <= '0;
            state   <= IDLE;
          end else if (sel_ack) begin
            // Ack beats a coincident timeout.
            p_cyc_o   <= '0;
            p_stb_o   <= '0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= p_we_o ? 32'h0 : sel_dat;
            state     <= RESP;
          end else if (wait_cnt == 8'(TIMEOUT)) begin
            p_cyc_o   <= '0;
            p_stb_o   <= '0;
            wbs_ack_o <= 1'b1;
            wbs_dat_o <= p_we_o ? 32'h0 : ERR_DATA;
            err_irq_o <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          // The ack was raised on entry; this edge ends the single ack cycle.
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= IDLE;
        end

        default: begin
          p_cyc_o   <= '0;
          p_stb_o   <= '0;
          wbs_ack_o <= 1'b0;
          wbs_dat_o <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// Directed bench for wb_periph_arbiter: a master task issues requests and
// queues the expected response; a monitor pops and compares on each ack.
module tb_wb_periph_arbiter;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack;
  logic [31:0]   rdat;
  logic [NP-1:0] p_cyc, p_stb;
  logic          p_we;
  logic [3:0]    p_sel;
  logic [11:0]   p_adr;
  logic [31:0]   p_dat;
  logic [NP-1:0] p_ack;
  logic [127:0]  p_dat_in;
  logic          err_irq;

  // Peripheral model state
  int            del [NP];
  logic [31:0]   pdata [NP];
  int            wcnt [NP];
  logic [NP-1:0] model_ack;
  logic [NP-1:0] force_ack;

  typedef struct {
    logic [31:0] dat;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  assign p_ack    = model_ack | force_ack;
  assign p_dat_in = {pdata[3], pdata[2], pdata[1], pdata[0]};

  always #5 clk = ~clk;

  wb_periph_arbiter #(.NPERIPH(NP), .TIMEOUT(255), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .p_cyc_o  (p_cyc),
    .p_stb_o  (p_stb),
    .p_we_o   (p_we),
    .p_sel_o  (p_sel),
    .p_adr_o  (p_adr),
    .p_dat_o  (p_dat),
    .p_ack_i  (p_ack),
    .p_dat_i  (p_dat_in),
    .err_irq_o(err_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Peripheral k acks in its del[k]-th strobe cycle (0 = first strobe cycle).
  initial begin
    model_ack = '0;
    for (int k = 0; k < NP; k++) wcnt[k] = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NP; k++) begin
        if (p_stb[k]) begin
          model_ack[k] = (wcnt[k] == del[k]);
          wcnt[k]++;
        end else begin
          model_ack[k] = 1'b0;
          wcnt[k] = 0;
        end
      end
    end
  end

  // Response monitor: each ack must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(ack), 32'h0);
          end else begin
            resp_t e;
            e = exp_q.pop_front();
            check("ack_data", rdat, e.dat);
            check("ack_err_irq", 32'(err_irq), 32'(e.err));
          end
        end else begin
          if (rdat !== 32'h0) check("dat_zero_without_ack", rdat, 32'h0);
          if (err_irq !== 1'b0) check("err_irq_without_ack", 32'(err_irq), 32'h0);
        end
      end
    end
  end

  // Issue one request; caller sits at a negedge. Leaves cyc/stb asserted.
  task automatic do_req(input string name, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [NP-1:0] exp_stb,
                        input int exp_lat, input logic [31:0] exp_dat, input logic exp_err);
    int n;
    resp_t e;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = a; wdat = d;
    e.dat = exp_dat; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge clk); n = 1;
    @(negedge clk);
    check({name, "_stb"}, 32'(p_stb), 32'(exp_stb));
    check({name, "_cyc"}, 32'(p_cyc), 32'(exp_stb));
    if (exp_stb != '0) begin
      check({name, "_adr"}, 32'(p_adr), 32'(a[11:0]));
      check({name, "_pdat"}, p_dat, d);
      check({name, "_we"}, 32'(p_we), 32'(w));
    end
    while (!ack && n < 1000) begin
      @(posedge clk); n++;
      @(negedge clk);
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic idle(input int cycles);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    force_ack = '0;
    for (int k = 0; k < NP; k++) begin del[k] = 0; pdata[k] = '0; end
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(ack), 32'h0);
    check("reset_dat", rdat, 32'h0);
    check("reset_stb", 32'(p_stb | p_cyc), 32'h0);
    check("reset_pbus", {p_adr, p_sel, 15'h0, p_we}, 32'h0);
    check("reset_pdat", p_dat, 32'h0);
    check("reset_irq", 32'(err_irq), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Write to periph1, first-cycle ack; write returns zero data.
    del[1] = 0; pdata[1] = 32'hFFFF_FFFF;
    do_req("wr_p1", 1'b1, 32'h3000_1004, 32'h1234_5678, 4'b0010, 2, 32'h0, 1'b0);
    idle(1);

    // Read periph3 after 5 wait cycles, with periph0's ack line stuck high.
    del[3] = 5; pdata[3] = 32'hCAFE_0001; force_ack = 4'b0001;
    do_req("rd_p3", 1'b0, 32'h3000_3010, 32'h0, 4'b1000, 7, 32'hCAFE_0001, 1'b0);
    idle(1);
    force_ack = '0;
    check("rd_p3_dat_after", rdat, 32'h0);

    // Decode errors: bit 14 and bit 15 set.
    do_req("dec_err14", 1'b0, 32'h3000_4000, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1);
    idle(1);
    do_req("dec_err15", 1'b1, 32'h0000_8000, 32'h5, 4'b0000, 1, 32'hDEAD_BEEF, 1'b1);
    idle(1);

    // Read timeout on periph0, then ack exactly on the timeout cycle.
    del[0] = 1000; pdata[0] = 32'h1111_2222;
    do_req("rd_timeout", 1'b0, 32'h3000_0000, 32'h0, 4'b0001, 257, 32'hDEAD_BEEF, 1'b1);
    idle(1);
    del[0] = 255;
    do_req("rd_ack_at_to", 1'b0, 32'h3000_0000, 32'h0, 4'b0001, 257, 32'h1111_2222, 1'b0);
    idle(1);

    // Write timeout returns zero data but still flags the error.
    del[2] = 1000; pdata[2] = 32'h7777_7777;
    do_req("wr_timeout", 1'b1, 32'h3000_2008, 32'h9, 4'b0100, 257, 32'h0, 1'b1);
    idle(1);

    // Back-to-back: second request presented in the IDLE cycle after RESP;
    // its upper address bits are don't-care.
    del[1] = 0; pdata[1] = 32'hAAAA_5555;
    del[2] = 0; pdata[2] = 32'h0BAD_F00D;
    do_req("b2b_a", 1'b0, 32'h3000_1000, 32'h0, 4'b0010, 2, 32'hAAAA_5555, 1'b0);
    do_req("b2b_b", 1'b0, 32'hABCD_2ABC, 32'h0, 4'b0100, 2, 32'h0BAD_F00D, 1'b0);
    idle(2);

    // Master abort while ACTIVE.
    del[2] = 1000;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_2000;
    @(posedge clk); @(negedge clk);
    check("abort_stb_on", 32'(p_stb), 32'(4'b0100));
    repeat (2) @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("abort_stb_off", 32'(p_stb | p_cyc), 32'h0);
    check("abort_no_ack", 32'(ack), 32'h0);
    idle(3);

    // Reset mid-transaction, then a late ack on every line.
    del[1] = 1000;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_1000;
    @(posedge clk); @(negedge clk);
    check("rst_mid_stb_on", 32'(p_stb), 32'(4'b0010));
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("rst_mid_stb_off", 32'(p_stb | p_cyc), 32'h0);
    check("rst_mid_no_ack", 32'(ack), 32'h0);
    rst = 1'b0;
    force_ack = 4'b1111;
    repeat (2) @(negedge clk);
    check("late_ack_ignored", {31'h0, ack}, 32'h0);
    check("late_ack_no_stb", 32'(p_stb), 32'h0);
    force_ack = '0;
    @(negedge clk);

    // Normal service after the reset.
    del[3] = 0;
    do_req("after_rst", 1'b1, 32'h3000_3FFC, 32'h0000_00A5, 4'b1000, 2, 32'h0, 1'b0);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
